// File: rtl/braille_tx.sv
// Serial Braille transmitter for ASCII digits '0'..'9'.
// Frame: two 0 start bits, dots 1,2,4,5, optional even-parity bit, then IDLE_GAP idle-high bits.
// A one-entry holding buffer lets the next digit be accepted mid-frame so frames run
// back-to-back. Non-digit characters are accepted, flagged on ERR for one cycle, and dropped.
// Optional feature: define BRAILLE_TX_PARITY_EN to append the parity bit after dot5.
module braille_tx #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [8:1] D,
  input  logic       VALID,
  output logic       READY,
  output logic       O,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {
    StIdle,
    StStart0,
    StStart1,
    StData,
    StGap
`ifdef BRAILLE_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  sh_q;
  logic        par_q;
  logic [3:0]  cnt_q;
  logic        buf_full_q;
  logic [3:0]  buf_pat_q;
  logic        o_q;
  logic        err_q;

  logic        is_digit;
  logic        acc;
  logic        acc_dig;
  logic [3:0]  acc_pat;
  logic        last_bit;
  logic        frame_end;
  logic        start_go;
  logic [3:0]  start_pat;
  logic        buf_load;

  // Dot pattern {dot1, dot2, dot4, dot5} for the low nibble of a digit.
  function automatic logic [3:0] enc(input logic [3:0] n);
    logic [3:0] p;
    case (n)
      4'd1:    p = 4'b1000;
      4'd2:    p = 4'b1100;
      4'd3:    p = 4'b1010;
      4'd4:    p = 4'b1011;
      4'd5:    p = 4'b1001;
      4'd6:    p = 4'b1110;
      4'd7:    p = 4'b1111;
      4'd8:    p = 4'b1101;
      4'd9:    p = 4'b0110;
      4'd0:    p = 4'b0111;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Handshake decode and frame sequencing decisions.
  always_comb begin
    is_digit = (D >= 8'h30) && (D <= 8'h39);
    acc      = VALID && !buf_full_q;
    acc_dig  = acc && is_digit;
    acc_pat  = enc(D[4:1]);
`ifdef BRAILLE_TX_PARITY_EN
    last_bit = (state_q == StParity);
`else
    last_bit = (state_q == StData) && (idx_q == 2'd3);
`endif
    // Edge on which the current bit is the final one of frame plus gap.
    frame_end = ((state_q == StGap) && (cnt_q == 4'd0)) || (last_bit && (IDLE_GAP == 0));
    // Buffered digit wins; otherwise a digit arriving on the final edge starts straight away.
    start_go  = ((state_q == StIdle) && acc_dig) || (frame_end && (buf_full_q || acc_dig));
    start_pat = buf_full_q ? buf_pat_q : acc_pat;
    buf_load  = acc_dig && (state_q != StIdle) && !frame_end;
  end

  // Frame FSM, holding buffer and registered outputs.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      sh_q       <= 4'd0;
      par_q      <= 1'b0;
      cnt_q      <= 4'd0;
      buf_full_q <= 1'b0;
      buf_pat_q  <= 4'd0;
      o_q        <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= acc && !is_digit;

      if (buf_load) begin
        buf_full_q <= 1'b1;
        buf_pat_q  <= acc_pat;
      end else if (start_go && buf_full_q) begin
        buf_full_q <= 1'b0;
      end

      if (start_go) begin
        state_q <= StStart0;
        o_q     <= 1'b0;
        sh_q    <= start_pat;
        par_q   <= ^start_pat;
      end else if (last_bit) begin
        if (IDLE_GAP != 0) begin
          state_q <= StGap;
          cnt_q   <= 4'(IDLE_GAP - 1);
        end else begin
          state_q <= StIdle;
        end
        o_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            o_q <= 1'b1;
          end
          StStart0: begin
            state_q <= StStart1;
            o_q     <= 1'b0;
          end
          StStart1: begin
            state_q <= StData;
            idx_q   <= 2'd0;
            o_q     <= sh_q[3];
            sh_q    <= {sh_q[2:0], 1'b0};
          end
          StData: begin
            // Only reached for idx 0..2 here; idx 3 without parity is last_bit.
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
              o_q   <= sh_q[3];
              sh_q  <= {sh_q[2:0], 1'b0};
            end else begin
`ifdef BRAILLE_TX_PARITY_EN
              state_q <= StParity;
              o_q     <= par_q;
`else
              state_q <= StIdle;
              o_q     <= 1'b1;
`endif
            end
          end
          StGap: begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q <= StIdle;
            end
            o_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            o_q     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign READY = !buf_full_q;
  assign BUSY  = (state_q != StIdle) || buf_full_q;
  assign O     = o_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_braille_tx.sv
// Bench for braille_tx: three instances (IDLE_GAP = 1, 0, 3) share inputs; each is compared
// every cycle against a frame-queue reference model, plus directed scenarios.
module tb_braille_tx;

  logic       CLK = 1'b0;
  logic       R;
  logic [8:1] D;
  logic       VALID;
  logic [2:0] ready_w, o_w, busy_w, err_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  braille_tx #(.IDLE_GAP(1)) u_dut_g1 (
    .CLK(CLK), .R(R), .D(D), .VALID(VALID),
    .READY(ready_w[0]), .O(o_w[0]), .BUSY(busy_w[0]), .ERR(err_w[0])
  );
  braille_tx #(.IDLE_GAP(0)) u_dut_g0 (
    .CLK(CLK), .R(R), .D(D), .VALID(VALID),
    .READY(ready_w[1]), .O(o_w[1]), .BUSY(busy_w[1]), .ERR(err_w[1])
  );
  braille_tx #(.IDLE_GAP(3)) u_dut_g3 (
    .CLK(CLK), .R(R), .D(D), .VALID(VALID),
    .READY(ready_w[2]), .O(o_w[2]), .BUSY(busy_w[2]), .ERR(err_w[2])
  );

  // Reference model state, one slot per instance.
  int          gap_of [3] = '{1, 0, 3};
  logic [3:0]  dots   [10];
  bit   [31:0] frm    [3];
  int          left   [3];
  bit          bfull  [3];
  logic [7:0]  bch    [3];
  bit          e_o    [3];
  bit          e_busy [3];
  bit          e_err  [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Whole frame as a bit list, first bit in position 0.
  task automatic load_frame(input int k, input logic [7:0] c);
    logic [3:0] p;
    int n;
    p = dots[c - 8'h30];
    frm[k] = '0;
    n = 2;
    for (int i = 3; i >= 0; i--) begin
      frm[k][n] = p[i];
      n++;
    end
`ifdef BRAILLE_TX_PARITY_EN
    frm[k][n] = ^p;
    n++;
`endif
    for (int g = 0; g < gap_of[k]; g++) begin
      frm[k][n] = 1'b1;
      n++;
    end
    left[k] = n;
  endtask

  task automatic pop_bit(input int k);
    e_o[k]  = frm[k][0];
    frm[k]  = frm[k] >> 1;
    left[k] = left[k] - 1;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit acc, used, active;
      if (R) begin
        left[k] = 0; bfull[k] = 0; e_o[k] = 1; e_busy[k] = 0; e_err[k] = 0;
      end else begin
        acc      = VALID && !bfull[k];
        e_err[k] = acc && !is_dig(D);
        used     = 0;
        active   = 1;
        if (left[k] > 0) begin
          pop_bit(k);
        end else if (bfull[k]) begin
          load_frame(k, bch[k]);
          pop_bit(k);
          bfull[k] = 0;
        end else if (acc && is_dig(D)) begin
          load_frame(k, D);
          pop_bit(k);
          used = 1;
        end else begin
          e_o[k] = 1;
          active = 0;
        end
        if (acc && is_dig(D) && !used) begin
          bfull[k] = 1;
          bch[k]   = D;
        end
        e_busy[k] = active || bfull[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("g%0d_o", gap_of[k]), 32'(o_w[k]), 32'(e_o[k]));
      check($sformatf("g%0d_busy", gap_of[k]), 32'(busy_w[k]), 32'(e_busy[k]));
      check($sformatf("g%0d_ready", gap_of[k]), 32'(ready_w[k]), 32'(!bfull[k]));
      check($sformatf("g%0d_err", gap_of[k]), 32'(err_w[k]), 32'(e_err[k]));
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    R = r; VALID = v; D = d;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    logic [7:0] seq;
    int busy_cnt;
    dots = '{4'b0111, 4'b1000, 4'b1100, 4'b1010, 4'b1011,
             4'b1001, 4'b1110, 4'b1111, 4'b1101, 4'b0110};
    for (int k = 0; k < 3; k++) begin
      left[k] = 0; bfull[k] = 0; bch[k] = 0; frm[k] = 0;
      e_o[k] = 1; e_busy[k] = 0; e_err[k] = 0;
    end

    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h31);  // VALID ignored during reset

    // '1' for one cycle: bit stream and BUSY length on the IDLE_GAP=1 instance.
    cyc(0, 1, 8'h31);
    seq = {7'd0, o_w[0]};
    busy_cnt = busy_w[0] ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 8'h00);
      seq = {seq[6:0], o_w[0]};
      busy_cnt += busy_w[0] ? 1 : 0;
    end
    check("digit1_stream", 32'(seq), 32'h23);
`ifndef BRAILLE_TX_PARITY_EN
    check("digit1_busy_len", 32'(busy_cnt), 32'd7);
`endif

    // '0' then '9' held: second goes into the buffer mid-frame.
    cyc(0, 1, 8'h30);
    cyc(0, 1, 8'h39);
    check("buffered_ready_low", 32'(ready_w[0]), 32'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00);

    // Non-digit: ERR pulse, no frame.
    cyc(0, 1, 8'h41);
    check("nondigit_err", 32'(err_w), 32'h7);
    check("nondigit_busy", 32'(busy_w), 32'h0);
    cyc(0, 0, 8'h00);
    check("nondigit_err_clear", 32'(err_w), 32'h0);

    // '7' aborted by reset after its third bit, then '2'.
    cyc(0, 1, 8'h37);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    check("abort_o", 32'(o_w), 32'h7);
    check("abort_busy", 32'(busy_w), 32'h0);
    check("abort_ready", 32'(ready_w), 32'h7);
    cyc(0, 1, 8'h32);
    for (int i = 0; i < 12; i++) cyc(0, 0, 8'h00);

    // '3','8','5' streamed on the IDLE_GAP=0 instance.
    cyc(0, 1, 8'h33);
    cyc(0, 1, 8'h38);
    for (int i = 0; i < 30; i++) cyc(0, 1, 8'h35);
    for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, v;
      logic [7:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) d = 8'($urandom_range(0, 255));
      else d = 8'h30 + 8'($urandom_range(0, 9));
      cyc(r, v, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
